// File: rtl/gate_vector_checker.sv
// Drives a/b through all four input pairs, checks the seven gate outputs after a
// settle delay and reports pass/fail. Optional macro: GATE_CHK_STOP_ON_ERR_EN.
module gate_vector_checker #(
  parameter int SETTLE_CYC = 2,
  parameter int LOOPS      = 1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       obs,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_mask
);

  localparam int CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

`ifdef GATE_CHK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         vec_q, vec_d;
  logic [LOOP_W-1:0]  loop_q, loop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_q, a_d, b_q, b_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d, err_nx;
  logic [3:0]         mask_q, mask_d, mask_nx;
  logic               mismatch;

  // Bit order {xnor, xor, nor, nand, not, or, and}
  function automatic logic [6:0] expected(input logic ea, input logic eb);
    return {~(ea ^ eb), ea ^ eb, ~(ea | eb), ~(ea & eb), ~ea, ea | eb, ea & eb};
  endfunction

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    loop_d   = loop_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    mask_d   = mask_q;

    mismatch = (obs != expected(vec_q[1], vec_q[0]));
    err_nx   = err_q;
    mask_nx  = mask_q;
    if (mismatch) begin
      err_nx  = (err_q == '1) ? err_q : err_q + ERR_W'(1);
      mask_nx = mask_q | (4'b0001 << vec_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = '0;
          mask_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          vec_d   = '0;
          loop_d  = '0;
          busy_d  = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        a_d     = vec_q[1];
        b_d     = vec_q[0];
        cnt_d   = CNT_W'(SETTLE_CYC - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CHECK: begin
        err_d  = err_nx;
        mask_d = mask_nx;
        // Early stop leaves a/b on the failing vector for debug
        if (STOP_ON_ERR && mismatch) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          state_d = S_DRIVE;
        end else if (loop_q != LOOP_W'(LOOPS - 1)) begin
          loop_d  = loop_q + LOOP_W'(1);
          vec_d   = '0;
          state_d = S_DRIVE;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          pass_d  = (err_nx == '0);
          busy_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      loop_q  <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Scoreboard bench for gate_vector_checker: ideal and faulty gate models on obs,
// expected run summaries queued at start acceptance and checked when done rises.
module tb_gate_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n, start0, start1;
  logic [1:0] mode0;
  logic [6:0] obs0, obs1, obs2;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic       a2, b2, busy2, done2, pass2;
  logic [7:0] err0, err1;
  logic [2:0] err2;
  logic [3:0] mask0, mask1, mask2;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int err; int mask; int pass; int a; int b; int lat; int due;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   ab_q[$];

  function automatic logic [6:0] gate_model(input logic ga, input logic gb);
    return {~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ~ga, ga | gb, ga & gb};
  endfunction

  function automatic exp_t mk(input int err, input int mask, input int pass,
                              input int ea, input int eb, input int lat);
    exp_t e;
    e.err = err; e.mask = mask; e.pass = pass; e.a = ea; e.b = eb; e.lat = lat; e.due = 0;
    return e;
  endfunction

  // mode0: 0 ideal, 1 nor forced 0, 2 xor stuck 0
  always_comb begin
    obs0 = gate_model(a0, b0);
    if (mode0 == 2'd1) obs0[4] = 1'b0;
    if (mode0 == 2'd2) obs0[5] = 1'b0;
  end
  always_comb obs1 = gate_model(a1, b1) | 7'b0000001;
  always_comb obs2 = gate_model(a2, b2) | 7'b0000001;

  gate_vector_checker #(.SETTLE_CYC(2), .LOOPS(1), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .start(start0), .obs(obs0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_mask(mask0));

  gate_vector_checker #(.SETTLE_CYC(2), .LOOPS(3), .ERR_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .obs(obs1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_mask(mask1));

  gate_vector_checker #(.SETTLE_CYC(2), .LOOPS(3), .ERR_W(3)) u_dut2 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .obs(obs2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_mask(mask2));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rec(input string tag, input exp_t e, input int err, input int mask,
                         input int pass, input int ea, input int eb);
    chk({tag, "_done_edge"}, cyc, e.due);
    chk({tag, "_err_cnt"}, err, e.err);
    chk({tag, "_fail_mask"}, mask, e.mask);
    chk({tag, "_pass"}, pass, e.pass);
    chk({tag, "_a"}, ea, e.a);
    chk({tag, "_b"}, eb, e.b);
  endtask

  task automatic unexpected(input string tag);
    n_chk++;
    n_fail++;
    $display("FAIL %s: done rose with no run outstanding", tag);
  endtask

  // Monitor: a/b trace while busy and run summary on every done rising edge
  logic d0p = 1'b0, d1p = 1'b0, d2p = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   v;
    if (busy0 && ab_q.size() > 0) begin
      v = ab_q.pop_front();
      chk("dut0_ab_trace", int'({a0, b0}), v);
    end
    if (done0 && !d0p) begin
      if (q0.size() == 0) unexpected("dut0");
      else begin
        e = q0.pop_front();
        chk_rec("dut0", e, int'(err0), int'(mask0), int'(pass0), int'(a0), int'(b0));
      end
    end
    if (done1 && !d1p) begin
      if (q1.size() == 0) unexpected("dut1");
      else begin
        e = q1.pop_front();
        chk_rec("dut1", e, int'(err1), int'(mask1), int'(pass1), int'(a1), int'(b1));
      end
    end
    if (done2 && !d2p) begin
      if (q2.size() == 0) unexpected("dut2");
      else begin
        e = q2.pop_front();
        chk_rec("dut2", e, int'(err2), int'(mask2), int'(pass2), int'(a2), int'(b2));
      end
    end
    d0p = done0;
    d1p = done1;
    d2p = done2;
  end

  task automatic pulse0(output int acc);
    @(negedge clk) start0 = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk) start0 = 1'b0;
  endtask

  task automatic go0(input logic [1:0] m, input exp_t e);
    int acc;
    mode0 = m;
    ab_q.delete();
    for (int k = 0; k < 16; k++) ab_q.push_back((k == 0) ? 0 : (k - 1) / 4);
    pulse0(acc);
    e.due = acc + e.lat;
    q0.push_back(e);
  endtask

  task automatic wait0();
    int n = 0;
    while (!(done0 && !busy0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut0_timeout: done=%0d required 1", done0);
    end
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_a"}, int'(a0), 0);
    chk({tag, "_b"}, int'(b0), 0);
    chk({tag, "_busy"}, int'(busy0), 0);
    chk({tag, "_done"}, int'(done0), 0);
    chk({tag, "_pass"}, int'(pass0), 0);
    chk({tag, "_err_cnt"}, int'(err0), 0);
    chk({tag, "_fail_mask"}, int'(mask0), 0);
  endtask

  initial begin
    int   acc, n;
    exp_t e1, e2;
    rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0; mode0 = 2'd2;
    #12;
    chk_reset0("reset");
    @(negedge clk) begin rst0_n = 1'b1; rst1_n = 1'b1; end
    repeat (2) @(negedge clk);

    go0(2'd0, mk(0, 0, 1, 0, 0, 16));
    wait0();

`ifdef GATE_CHK_STOP_ON_ERR_EN
    go0(2'd1, mk(1, 1, 0, 0, 0, 4));
    wait0();
    go0(2'd2, mk(1, 2, 0, 0, 1, 8));
    wait0();
`else
    go0(2'd1, mk(1, 1, 0, 0, 0, 16));
    wait0();
    go0(2'd2, mk(2, 6, 0, 0, 0, 16));
    wait0();
`endif

    // Async reset in SETTLE of vector 2 (a=1, b=0)
    mode0 = 2'd0;
    ab_q.delete();
    pulse0(acc);
    repeat (9) @(negedge clk);
    chk("pre_reset_a", int'(a0), 1);
    chk("pre_reset_b", int'(b0), 0);
    #2 rst0_n = 1'b0;
    #1 chk_reset0("midrun_reset");
    @(negedge clk) rst0_n = 1'b1;
    repeat (2) @(negedge clk);

    // A start pulse while busy must not disturb the run
    go0(2'd0, mk(0, 0, 1, 0, 0, 16));
    repeat (5) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    wait0();
    repeat (3) @(negedge clk);
    chk("after_ignored_busy", int'(busy0), 0);
    chk("after_ignored_done", int'(done0), 1);

    // Three loops with and stuck at 1, wide and narrow error counters
`ifdef GATE_CHK_STOP_ON_ERR_EN
    e1 = mk(1, 1, 0, 0, 0, 4);
    e2 = mk(1, 1, 0, 0, 0, 4);
`else
    e1 = mk(9, 7, 0, 0, 0, 48);
    e2 = mk(7, 7, 0, 0, 0, 48);
`endif
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    e1.due = acc + e1.lat;
    e2.due = acc + e2.lat;
    q1.push_back(e1);
    q2.push_back(e2);
    @(negedge clk) start1 = 1'b0;
    n = 0;
    while (!(done1 && done2) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut12_timeout: done1=%0d done2=%0d required 1", done1, done2);
    end
    repeat (2) @(negedge clk);

    n_chk++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d runs outstanding, required 0",
               q0.size() + q1.size() + q2.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
